// File: rtl/serial_tx_reg.sv
// Parallel-in, serial-out transmitter feeding a downstream shift-register chain.
// A word captured on Load is presented one bit per cycle with a shift-enable
// strobe; the downstream register samples Shift_Out on the same clock edge.
module serial_tx_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Fill_In,
  input  logic             Hold,
  output logic             Shift_Out,
  output logic             Shift_En_Out,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Data_Out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [WIDTH-1:0]   w_q_shifted;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Register contents after consuming one bit, with Fill_In entering the vacated end
  always_comb begin
    if (MSB_FIRST) begin
      w_q_shifted = {r_q[WIDTH-2:0], Fill_In};
    end else begin
      w_q_shifted = {Fill_In, r_q[WIDTH-1:1]};
    end
  end

  // State, shift register and bit counter update; Reset has priority over everything
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: load from IDLE/DONE, shift unless held, one-cycle DONE
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (Load) begin
          w_q_nxt     = D;
          w_cnt_nxt   = CNT_W'(WIDTH);
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Load is deliberately ignored while a transfer is in flight
        if (!Hold && (r_cnt != '0)) begin
          w_q_nxt   = w_q_shifted;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A Load here starts the next word with no idle gap
        if (Load) begin
          w_q_nxt     = D;
          w_cnt_nxt   = CNT_W'(WIDTH);
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from state, register contents and Hold
  always_comb begin
    Shift_Out    = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];
    Busy         = (r_state == S_SHIFT);
    Shift_En_Out = (r_state == S_SHIFT) && !Hold;
    Done         = (r_state == S_DONE);
    Data_Out     = r_q;
  end

endmodule
